// File: rtl/beta_pipe_ctrl_unit.sv
// Hazard and sequencing controller for the IF/DEC/EXE/MEM in-order pipeline.
// Generates stall, bubble, flush and PC-select for load-use, CSR/SYSTEM serialisation and redirects.
`timescale 1ns/1ps
module beta_pipe_ctrl_unit #(
   parameter int LOAD_USE_CYCLES = 1,
   parameter int FLUSH_CYCLES    = 2,
   parameter int CNT_W           = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       dec_valid_i,
   input  logic [4:0] dec_rs1_i,
   input  logic [4:0] dec_rs2_i,
   input  logic [1:0] dec_src_reg_used_i,
   input  logic [1:0] dec_sys_priv_en_i,
   input  logic       dec_csr_en_i,
   input  logic       exe_valid_i,
   input  logic [4:0] exe_rd_i,
   input  logic       exe_reg_wr_en_i,
   input  logic       exe_mem_op_en_i,
   input  logic       exe_mem_op_i,
   input  logic       mem_valid_i,
   input  logic       exe_redirect_i,
   input  logic [1:0] exe_redirect_kind_i,
   output logic       if_stall_o,
   output logic       dec_stall_o,
   output logic       exe_bubble_o,
   output logic       if_flush_o,
   output logic       dec_flush_o,
   output logic [1:0] pc_sel_o,
   output logic       busy_o
);

   localparam int MAX_CYCLES = (LOAD_USE_CYCLES > FLUSH_CYCLES) ? LOAD_USE_CYCLES : FLUSH_CYCLES;

   if (CNT_W < $clog2(MAX_CYCLES + 1)) begin : g_cnt_w_check
      $error("CNT_W too narrow for LOAD_USE_CYCLES/FLUSH_CYCLES");
   end

   localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] LDST_INIT  = CNT_W'(LOAD_USE_CYCLES - 2);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      DRAIN   = 2'd2,
      FLUSH   = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_dec;

   logic rs1_used;
   logic rs2_used;
   logic lu_haz;
   logic sys_haz;
   logic redir;

   logic       stall;
   logic       iflush;
   logic       dflush;
   logic [1:0] pcsel;

   // src encoding: 00 rs1 only, 01 rs1+rs2, 10/11 no sources
   assign rs1_used = (dec_src_reg_used_i == 2'b00) || (dec_src_reg_used_i == 2'b01);
   assign rs2_used = (dec_src_reg_used_i == 2'b01);

   assign lu_haz = dec_valid_i && exe_valid_i && exe_mem_op_en_i && !exe_mem_op_i &&
                   exe_reg_wr_en_i && (exe_rd_i != 5'd0) &&
                   ((rs1_used && (dec_rs1_i == exe_rd_i)) ||
                    (rs2_used && (dec_rs2_i == exe_rd_i)));

   assign sys_haz = dec_valid_i && ((dec_sys_priv_en_i != 2'b00) || dec_csr_en_i) &&
                    (exe_valid_i || mem_valid_i);

   assign redir = exe_redirect_i && (exe_redirect_kind_i != 2'b00);

   assign cnt_dec = (cnt == '0) ? cnt : cnt - CNT_W'(1);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = 1'b0;
      iflush    = 1'b0;
      dflush    = 1'b0;
      pcsel     = 2'b00;
      if (redir) begin
         pcsel     = exe_redirect_kind_i;
         iflush    = 1'b1;
         dflush    = 1'b1;
         state_nxt = FLUSH;
         cnt_nxt   = FLUSH_INIT;
      end else begin
         case (state)
            RUN: begin
               if (sys_haz) begin
                  stall     = 1'b1;
                  state_nxt = DRAIN;
               end else if (lu_haz) begin
                  stall = 1'b1;
                  if (LOAD_USE_CYCLES > 1) begin
                     state_nxt = LDSTALL;
                     cnt_nxt   = LDST_INIT;
                  end
               end
            end
            LDSTALL: begin
               stall = 1'b1;
               if (sys_haz) begin
                  state_nxt = DRAIN;
               end else if (cnt == '0) begin
                  state_nxt = RUN;
               end else begin
                  cnt_nxt = cnt_dec;
               end
            end
            DRAIN: begin
               // release in the cycle EXE and MEM are both empty
               if (exe_valid_i || mem_valid_i) begin
                  stall = 1'b1;
               end else begin
                  state_nxt = RUN;
               end
            end
            FLUSH: begin
               iflush = 1'b1;
               if (cnt == '0) begin
                  state_nxt = RUN;
               end else begin
                  cnt_nxt = cnt_dec;
               end
            end
            default: begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign if_stall_o   = rst_ni && stall;
   assign dec_stall_o  = rst_ni && stall;
   assign exe_bubble_o = rst_ni && stall;
   assign if_flush_o   = rst_ni && iflush;
   assign dec_flush_o  = rst_ni && dflush;
   assign pc_sel_o     = rst_ni ? pcsel : 2'b00;
   assign busy_o       = rst_ni && (state != RUN);

endmodule
